rom_fetch: RTL and testbench

ROM_FETCH -- requirements
Module: rom_fetch

---
 rtl/rom_fetch.sv | 112 +++++++++++
 tb/tb_rom_fetch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch.sv
// Instruction fetch front end for a synchronous ROM with a one-cycle registered read port.
// It issues word addresses, tracks the word in flight, and hands instructions to decode.
module rom_fetch #(
  parameter int WIDTH      = 32,
  parameter int ADDR_BITS  = 10,
  parameter int RESET_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic [ADDR_BITS-1:0] fe_addr,
  output logic                 fe_oe,
  output logic                 fe_hold,
  input  logic [WIDTH-1:0]     fe_q,
  input  logic                 jump_valid,
  input  logic [ADDR_BITS-1:0] jump_addr,
  input  logic                 halt,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_instr,
  output logic [ADDR_BITS-1:0] out_pc,
  input  logic                 out_ready,
  output logic [31:0]          fetch_count
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    STALL  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [ADDR_BITS-1:0] RESET_PC = ADDR_BITS'(RESET_ADDR);

  state_t               state;
  logic [ADDR_BITS-1:0] pc;
  logic                 inflight_valid;
  logic [ADDR_BITS-1:0] inflight_pc;
  logic                 adv;
  logic                 active;

  assign adv       = ~inflight_valid | out_ready;
  assign active    = (state == RUN) || (state == STALL);
  assign fe_addr   = pc;
  assign out_valid = inflight_valid;
  assign out_pc    = inflight_pc;
  assign out_instr = fe_q;

  // A jump squashes the ROM read and releases the hold so the stale word is dropped.
  always_comb begin
    fe_oe   = 1'b0;
    fe_hold = 1'b0;
    if (active && !jump_valid) begin
      fe_hold = ~adv;
      fe_oe   = ~(halt & adv);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
    end else begin
      case (state)
        BOOT: begin
          inflight_valid <= 1'b0;
          state          <= RUN;
        end
        RUN, STALL: begin
          if (jump_valid) begin
            pc             <= jump_addr;
            inflight_valid <= 1'b0;
            state          <= RUN;
          end else if (!adv) begin
            state <= STALL;
          end else if (halt) begin
            inflight_valid <= 1'b0;
            state          <= HALTED;
          end else begin
            pc             <= pc + ADDR_BITS'(1);
            inflight_pc    <= pc;
            inflight_valid <= 1'b1;
            state          <= RUN;
          end
        end
        HALTED: begin
          inflight_valid <= 1'b0;
          if (jump_valid) begin
            pc    <= jump_addr;
            state <= RUN;
          end else if (!halt) begin
            state <= RUN;
          end
        end
        default: begin
          inflight_valid <= 1'b0;
          state          <= BOOT;
        end
      endcase
    end
  end

  // Counts every handshake, including the one that coincides with a jump.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count <= '0;
    end else if (inflight_valid && out_ready) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_rom_fetch.sv
// Directed bench for rom_fetch: two instances (reset address 0 and 0x3FE), each with
// a registered ROM model holding ROM[i] = i + 100.
module tb_rom_fetch;

  logic        clk;
  logic        reset_n;
  logic [9:0]  fe_addr;
  logic        fe_oe;
  logic        fe_hold;
  logic [31:0] fe_q;
  logic        jump_valid;
  logic [9:0]  jump_addr;
  logic        halt;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [9:0]  out_pc;
  logic        out_ready;
  logic [31:0] fetch_count;

  logic [9:0]  fe_addr_w;
  logic        fe_oe_w;
  logic        fe_hold_w;
  logic [31:0] fe_q_w;
  logic        jump_valid_w;
  logic [9:0]  jump_addr_w;
  logic        halt_w;
  logic        out_valid_w;
  logic [31:0] out_instr_w;
  logic [9:0]  out_pc_w;
  logic        out_ready_w;
  logic [31:0] fetch_count_w;

  int checks;
  int passes;

  rom_fetch #(.WIDTH(32), .ADDR_BITS(10), .RESET_ADDR(0)) dut (
    .clk(clk), .reset_n(reset_n), .fe_addr(fe_addr), .fe_oe(fe_oe), .fe_hold(fe_hold),
    .fe_q(fe_q), .jump_valid(jump_valid), .jump_addr(jump_addr), .halt(halt),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .fetch_count(fetch_count)
  );

  rom_fetch #(.WIDTH(32), .ADDR_BITS(10), .RESET_ADDR(10'h3FE)) dut_w (
    .clk(clk), .reset_n(reset_n), .fe_addr(fe_addr_w), .fe_oe(fe_oe_w), .fe_hold(fe_hold_w),
    .fe_q(fe_q_w), .jump_valid(jump_valid_w), .jump_addr(jump_addr_w), .halt(halt_w),
    .out_valid(out_valid_w), .out_instr(out_instr_w), .out_pc(out_pc_w),
    .out_ready(out_ready_w), .fetch_count(fetch_count_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ROM: output enable low returns zero, hold freezes the data register.
  always @(posedge clk) begin
    if (!fe_hold) fe_q <= fe_oe ? (32'(fe_addr) + 32'd100) : 32'd0;
    if (!fe_hold_w) fe_q_w <= fe_oe_w ? (32'(fe_addr_w) + 32'd100) : 32'd0;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish first");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (fe_oe !== 1'b0) $display("[TB] FAIL reset_fe_oe: got %0b expected 0", fe_oe); else passes++;
    checks++; if (fe_hold !== 1'b0) $display("[TB] FAIL reset_fe_hold: got %0b expected 0", fe_hold); else passes++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); else passes++;
    checks++; if (fe_addr !== 10'h000) $display("[TB] FAIL reset_fe_addr: got %0h expected 0", fe_addr); else passes++;
    checks++; if (fetch_count !== 32'd0) $display("[TB] FAIL reset_count: got %0d expected 0", fetch_count); else passes++;
    checks++; if (fe_addr_w !== 10'h3FE) $display("[TB] FAIL reset_fe_addr_w: got %0h expected 3fe", fe_addr_w); else passes++;
    reset_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [9:0] exp_pc;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL boot_out_valid: got %0b expected 0", out_valid); else passes++;
    checks++; if (fe_oe !== 1'b1) $display("[TB] FAIL run_fe_oe: got %0b expected 1", fe_oe); else passes++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) $display("[TB] FAIL first_out_valid: got %0b expected 1", out_valid); else passes++;
    checks++; if (out_pc !== 10'h000) $display("[TB] FAIL first_out_pc: got %0h expected 0", out_pc); else passes++;
    checks++; if (out_instr !== 32'd100) $display("[TB] FAIL first_out_instr: got %0d expected 100", out_instr); else passes++;
    checks++; if (fe_addr !== 10'h001) $display("[TB] FAIL first_fe_addr: got %0h expected 1", fe_addr); else passes++;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      exp_pc = 10'(i);
      checks++; if (out_pc !== exp_pc) $display("[TB] FAIL seq_out_pc: got %0h expected %0h", out_pc, exp_pc); else passes++;
      checks++; if (out_instr !== 32'(i + 100)) $display("[TB] FAIL seq_out_instr: got %0d expected %0d", out_instr, i + 100); else passes++;
    end
    checks++; if (fetch_count !== 32'd3) $display("[TB] FAIL seq_count: got %0d expected 3", fetch_count); else passes++;
  endtask

  task automatic test_stall();
    repeat (2) @(negedge clk);
    checks++; if (out_pc !== 10'h005) $display("[TB] FAIL pre_stall_pc: got %0h expected 5", out_pc); else passes++;
    out_ready = 1'b0;
    #1;
    checks++; if (fe_hold !== 1'b1) $display("[TB] FAIL stall_hold_comb: got %0b expected 1", fe_hold); else passes++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_pc !== 10'h005) $display("[TB] FAIL stall_out_pc: got %0h expected 5", out_pc); else passes++;
      checks++; if (out_instr !== 32'd105) $display("[TB] FAIL stall_out_instr: got %0d expected 105", out_instr); else passes++;
      checks++; if (fe_hold !== 1'b1) $display("[TB] FAIL stall_fe_hold: got %0b expected 1", fe_hold); else passes++;
      checks++; if (fe_addr !== 10'h006) $display("[TB] FAIL stall_fe_addr: got %0h expected 6", fe_addr); else passes++;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (fe_hold !== 1'b0) $display("[TB] FAIL release_hold: got %0b expected 0", fe_hold); else passes++;
    @(negedge clk);
    checks++; if (out_pc !== 10'h006) $display("[TB] FAIL release_out_pc: got %0h expected 6", out_pc); else passes++;
    checks++; if (out_instr !== 32'd106) $display("[TB] FAIL release_out_instr: got %0d expected 106", out_instr); else passes++;
    checks++; if (fetch_count !== 32'd6) $display("[TB] FAIL release_count: got %0d expected 6", fetch_count); else passes++;
  endtask

  task automatic test_jump();
    @(negedge clk);
    checks++; if (out_pc !== 10'h007) $display("[TB] FAIL pre_jump_pc: got %0h expected 7", out_pc); else passes++;
    jump_valid = 1'b1;
    jump_addr  = 10'h200;
    #1;
    checks++; if (fe_oe !== 1'b0) $display("[TB] FAIL jump_fe_oe: got %0b expected 0", fe_oe); else passes++;
    checks++; if (fe_hold !== 1'b0) $display("[TB] FAIL jump_fe_hold: got %0b expected 0", fe_hold); else passes++;
    @(negedge clk);
    jump_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL jump_bubble_valid: got %0b expected 0", out_valid); else passes++;
    checks++; if (fetch_count !== 32'd8) $display("[TB] FAIL jump_count: got %0d expected 8", fetch_count); else passes++;
    checks++; if (fe_addr !== 10'h200) $display("[TB] FAIL jump_fe_addr: got %0h expected 200", fe_addr); else passes++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) $display("[TB] FAIL jump_target_valid: got %0b expected 1", out_valid); else passes++;
    checks++; if (out_pc !== 10'h200) $display("[TB] FAIL jump_target_pc: got %0h expected 200", out_pc); else passes++;
    checks++; if (out_instr !== 32'd612) $display("[TB] FAIL jump_target_instr: got %0d expected 612", out_instr); else passes++;
    @(negedge clk);
    checks++; if (out_pc !== 10'h201) $display("[TB] FAIL jump_next_pc: got %0h expected 201", out_pc); else passes++;
    checks++; if (fetch_count !== 32'd9) $display("[TB] FAIL jump_next_count: got %0d expected 9", fetch_count); else passes++;
  endtask

  task automatic test_jump_stall();
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (out_pc !== 10'h201) $display("[TB] FAIL jstall_pc: got %0h expected 201", out_pc); else passes++;
    checks++; if (fe_hold !== 1'b1) $display("[TB] FAIL jstall_hold: got %0b expected 1", fe_hold); else passes++;
    jump_valid = 1'b1;
    jump_addr  = 10'h050;
    #1;
    checks++; if (fe_hold !== 1'b0) $display("[TB] FAIL jstall_jump_hold: got %0b expected 0", fe_hold); else passes++;
    @(negedge clk);
    jump_valid = 1'b0;
    out_ready  = 1'b1;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL jstall_bubble: got %0b expected 0", out_valid); else passes++;
    checks++; if (fetch_count !== 32'd9) $display("[TB] FAIL jstall_count: got %0d expected 9", fetch_count); else passes++;
    @(negedge clk);
    checks++; if (out_pc !== 10'h050) $display("[TB] FAIL jstall_target_pc: got %0h expected 50", out_pc); else passes++;
    checks++; if (out_instr !== 32'd180) $display("[TB] FAIL jstall_target_instr: got %0d expected 180", out_instr); else passes++;
    @(negedge clk);
    checks++; if (out_pc !== 10'h051) $display("[TB] FAIL jstall_next_pc: got %0h expected 51", out_pc); else passes++;
  endtask

  task automatic test_halt();
    halt = 1'b1;
    #1;
    checks++; if (fe_oe !== 1'b0) $display("[TB] FAIL halt_fe_oe: got %0b expected 0", fe_oe); else passes++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) $display("[TB] FAIL halted_valid: got %0b expected 0", out_valid); else passes++;
      checks++; if (fe_addr !== 10'h052) $display("[TB] FAIL halted_fe_addr: got %0h expected 52", fe_addr); else passes++;
    end
    halt = 1'b0;
    @(negedge clk);
    checks++; if (fe_oe !== 1'b1) $display("[TB] FAIL resume_fe_oe: got %0b expected 1", fe_oe); else passes++;
    checks++; if (fetch_count !== 32'd11) $display("[TB] FAIL resume_count: got %0d expected 11", fetch_count); else passes++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) $display("[TB] FAIL resume_valid: got %0b expected 1", out_valid); else passes++;
    checks++; if (out_pc !== 10'h052) $display("[TB] FAIL resume_pc: got %0h expected 52", out_pc); else passes++;
    checks++; if (out_instr !== 32'd182) $display("[TB] FAIL resume_instr: got %0d expected 182", out_instr); else passes++;
  endtask

  task automatic test_reset_in_halt();
    halt = 1'b1;
    @(negedge clk);
    checks++; if (fetch_count !== 32'd12) $display("[TB] FAIL rhalt_count_before: got %0d expected 12", fetch_count); else passes++;
    reset_n = 1'b0;
    #1;
    checks++; if (fetch_count !== 32'd0) $display("[TB] FAIL rhalt_count_cleared: got %0d expected 0", fetch_count); else passes++;
    checks++; if (fe_addr !== 10'h000) $display("[TB] FAIL rhalt_fe_addr: got %0h expected 0", fe_addr); else passes++;
    checks++; if (fe_oe !== 1'b0) $display("[TB] FAIL rhalt_fe_oe: got %0b expected 0", fe_oe); else passes++;
    halt = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL rhalt_boot_valid: got %0b expected 0", out_valid); else passes++;
    @(negedge clk);
    checks++; if (out_pc !== 10'h000) $display("[TB] FAIL rhalt_restart_pc: got %0h expected 0", out_pc); else passes++;
    checks++; if (out_instr !== 32'd100) $display("[TB] FAIL rhalt_restart_instr: got %0d expected 100", out_instr); else passes++;
  endtask

  task automatic test_wrap();
    logic [9:0]  exp_pc [4];
    logic [31:0] exp_instr [4];
    exp_pc    = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    exp_instr = '{32'd1122, 32'd1123, 32'd100, 32'd101};
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid_w !== 1'b0) $display("[TB] FAIL wrap_boot_valid: got %0b expected 0", out_valid_w); else passes++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (out_valid_w !== 1'b1) $display("[TB] FAIL wrap_valid: got %0b expected 1", out_valid_w); else passes++;
      checks++; if (out_pc_w !== exp_pc[i]) $display("[TB] FAIL wrap_pc: got %0h expected %0h", out_pc_w, exp_pc[i]); else passes++;
      checks++; if (out_instr_w !== exp_instr[i]) $display("[TB] FAIL wrap_instr: got %0d expected %0d", out_instr_w, exp_instr[i]); else passes++;
    end
    checks++; if (fetch_count_w !== 32'd3) $display("[TB] FAIL wrap_count: got %0d expected 3", fetch_count_w); else passes++;
  endtask

  initial begin
    checks       = 0;
    passes       = 0;
    reset_n      = 1'b0;
    out_ready    = 1'b1;
    jump_valid   = 1'b0;
    jump_addr    = 10'h000;
    halt         = 1'b0;
    out_ready_w  = 1'b1;
    jump_valid_w = 1'b0;
    jump_addr_w  = 10'h000;
    halt_w       = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_jump_stall();
    test_halt();
    test_reset_in_halt();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
